seq_det_arbiter: RTL and testbench
==================================

SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, meaning the number of bits streamed per grant (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 4 bits: per-requester request; bit i is requester i.
REQ-005 SHALL have port w, input, 4 bits: per-requester serial data bit.
REQ-006 SHALL have port det_z, input, 1 bit: output of the shared consecutive-ones Moore detector.
REQ-007 SHALL have port gnt, output, 4 bits: one-hot grant, high only in STREAM.
REQ-008 SHALL have port det_w, output, 1 bit: detector input, equal to w[owner] in STREAM, else 0 (combinational).
REQ-009 SHALL have port det_reset, output, 1 bit: detector clear, 1 in IDLE and ARB, else 0.
REQ-010 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: registered one-cycle pulse in the cycle after FLUSH.
REQ-012 SHALL have port res_hit, output, 1 bit: latched result of the last completed burst.
REQ-013 SHALL have port res_owner, output, 2 bits: requester index of the last completed burst.

Function
REQ-014 SHALL implement states IDLE=00, ARB=01, STREAM=10, FLUSH=11 in a 2-bit register.
REQ-015 SHALL transition IDLE->ARB when req!=0; otherwise stay in IDLE.
REQ-016 SHALL, in ARB, latch owner as the first set req bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4), set ptr=owner, clear the bit counter and hit flag, then go to STREAM.
REQ-017 SHALL, when req is 0 in ARB, return to IDLE without changing ptr.
REQ-018 SHALL, in STREAM, increment the 4-bit bit counter each cycle and go to FLUSH on the cycle the counter equals BURST_LEN-1.
REQ-019 SHALL set the sticky hit flag in any STREAM or FLUSH cycle where det_z=1.
REQ-020 SHALL, in FLUSH (one cycle, covering the final bit's detector latency), go to ARB if req!=0, else to IDLE.
REQ-021 SHALL, on leaving FLUSH, load res_hit with the sticky flag (including that cycle's det_z) and res_owner with owner, and set done for exactly the next cycle.
REQ-022 SHALL abort when req[owner] falls during STREAM: next state IDLE, no done pulse, res_* unchanged, ptr keeps the aborted owner.
REQ-023 SHALL give requests arriving during STREAM/FLUSH no effect until the next ARB; there is no preemption.
REQ-024 SHALL keep gnt one-hot or zero in every cycle.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, set state=IDLE, ptr=3, owner=0, counter=0, hit flag=0, res_hit=0, res_owner=0, done=0, overriding all other activity including mid-STREAM.
REQ-026 SHALL produce gnt=0, det_w=0, det_reset=1 and busy=0 in the cycle after reset.

Configuration
REQ-027 SHALL, when ARB_HIT_COUNT_EN is defined, add output hit_cnt (4 bits): count of det_z=1 cycles in STREAM+FLUSH, saturating at 15, latched with res_hit, reset to 0.
REQ-028 SHALL, when ARB_HIT_COUNT_EN is undefined, omit the hit_cnt port and counter, leaving all other behaviour identical.

Verification (BURST_LEN=8)
REQ-029 SHALL cover: req=0001 and w[0]=1,1,0,0,0,0,0,0 -> gnt=0001 for 8 cycles; done pulses; res_hit=1, res_owner=0.
REQ-030 SHALL cover: req=1111 held -> owners 0,1,2,3,0 in order, FLUSH->ARB with no IDLE gap, det_reset=1 in each ARB.
REQ-031 SHALL cover: w=1,0,1,0,1,0,1,0 -> res_hit=0; w=0,0,0,0,0,0,1,1 -> hit seen only in FLUSH, res_hit=1.
REQ-032 SHALL cover: req[owner] dropped at STREAM cycle 3 -> IDLE next cycle, gnt=0, no done, res_* unchanged.
REQ-033 SHALL cover: reset asserted mid-STREAM -> next cycle IDLE, gnt=0, ptr=3; a subsequent req=1111 grants requester 0.
REQ-034 SHALL cover, with ARB_HIT_COUNT_EN: w=11111111 -> hit_cnt=7, res_hit=1.

Source files
------------

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that streams BURST_LEN serial bits from one requester into a shared
// consecutive-ones detector and latches the burst result. Define ARB_HIT_COUNT_EN to add hit_cnt.
module seq_det_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] w,
  input  logic       det_z,
  output logic [3:0] gnt,
  output logic       det_w,
  output logic       det_reset,
  output logic       busy,
  output logic       done,
  output logic       res_hit,
  output logic [1:0] res_owner
`ifdef ARB_HIT_COUNT_EN
  ,
  output logic [3:0] hit_cnt
`endif
);

  // state  | meaning
  // IDLE   | no requests, detector held clear
  // ARB    | pick next owner round-robin after ptr, detector held clear
  // STREAM | owner's w routed to detector for BURST_LEN cycles
  // FLUSH  | absorb detector latency of the final bit, publish result
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARB    = 2'b01,
    STREAM = 2'b10,
    FLUSH  = 2'b11
  } state_e;

  localparam logic [3:0] LAST = 4'(BURST_LEN - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hit_q, hit_d;
  logic       res_hit_q, res_hit_d;
  logic [1:0] res_owner_q, res_owner_d;
  logic       done_q, done_d;
  logic       hit_now;
  logic [1:0] cand [4];
  logic [1:0] arb_idx;

`ifdef ARB_HIT_COUNT_EN
  logic [3:0] hc_q, hc_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] hc_now;
`endif

  assign cand[0] = ptr_q + 2'd1;
  assign cand[1] = ptr_q + 2'd2;
  assign cand[2] = ptr_q + 2'd3;
  assign cand[3] = ptr_q;

  // Scan from lowest priority up so the nearest requester after ptr wins.
  always_comb begin
    arb_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[cand[k]]) arb_idx = cand[k];
    end
  end

  assign hit_now = hit_q | det_z;

`ifdef ARB_HIT_COUNT_EN
  assign hc_now = (det_z && hc_q != 4'hf) ? hc_q + 4'd1 : hc_q;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    res_hit_d   = res_hit_q;
    res_owner_d = res_owner_q;
    done_d      = 1'b0;
`ifdef ARB_HIT_COUNT_EN
    hc_d        = hc_q;
    hit_cnt_d   = hit_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (|req) begin
          owner_d = arb_idx;
          ptr_d   = arb_idx;
          cnt_d   = 4'd0;
          hit_d   = 1'b0;
`ifdef ARB_HIT_COUNT_EN
          hc_d    = 4'd0;
`endif
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        hit_d = hit_now;
        cnt_d = cnt_q + 4'd1;
`ifdef ARB_HIT_COUNT_EN
        hc_d  = hc_now;
`endif
        if (!req[owner_q])     state_d = IDLE;
        else if (cnt_q == LAST) state_d = FLUSH;
      end
      FLUSH: begin
        hit_d       = hit_now;
        res_hit_d   = hit_now;
        res_owner_d = owner_q;
        done_d      = 1'b1;
`ifdef ARB_HIT_COUNT_EN
        hc_d        = hc_now;
        hit_cnt_d   = hc_now;
`endif
        state_d     = (|req) ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd3;
      owner_q     <= 2'd0;
      cnt_q       <= 4'd0;
      hit_q       <= 1'b0;
      res_hit_q   <= 1'b0;
      res_owner_q <= 2'd0;
      done_q      <= 1'b0;
`ifdef ARB_HIT_COUNT_EN
      hc_q        <= 4'd0;
      hit_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      res_hit_q   <= res_hit_d;
      res_owner_q <= res_owner_d;
      done_q      <= done_d;
`ifdef ARB_HIT_COUNT_EN
      hc_q        <= hc_d;
      hit_cnt_q   <= hit_cnt_d;
`endif
    end
  end

  assign gnt       = (state_q == STREAM) ? (4'b0001 << owner_q) : 4'b0000;
  assign det_w     = (state_q == STREAM) ? w[owner_q] : 1'b0;
  assign det_reset = (state_q == IDLE) || (state_q == ARB);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign res_hit   = res_hit_q;
  assign res_owner = res_owner_q;
`ifdef ARB_HIT_COUNT_EN
  assign hit_cnt   = hit_cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: drives bursts into the DUT with a behavioural two-in-a-row
// detector attached, predicting owner/result per burst from round-robin and adjacent-ones rules.
module tb_seq_det_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] w = 4'b0;
  logic       det_z;
  logic [3:0] gnt;
  logic       det_w, det_reset, busy, done, res_hit;
  logic [1:0] res_owner;
`ifdef ARB_HIT_COUNT_EN
  logic [3:0] hit_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic [1:0] ptr_m;
  logic       res_hit_m;
  logic [1:0] res_owner_m;
  logic [3:0] hit_cnt_m;

  seq_det_arbiter #(.BURST_LEN(8)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .w(w),
    .det_z(det_z),
    .gnt(gnt),
    .det_w(det_w),
    .det_reset(det_reset),
    .busy(busy),
    .done(done),
    .res_hit(res_hit),
    .res_owner(res_owner)
`ifdef ARB_HIT_COUNT_EN
    ,
    .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Moore detector: output high once the last two accepted inputs were both 1.
  logic [1:0] dcnt = 2'd0;
  always @(posedge clk) begin
    if (reset || det_reset) dcnt <= 2'd0;
    else if (det_w)         dcnt <= (dcnt == 2'd2) ? 2'd2 : dcnt + 2'd1;
    else                    dcnt <= 2'd0;
  end
  assign det_z = (dcnt == 2'd2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] c;
    for (int k = 1; k <= 4; k++) begin
      c = 2'((int'(p) + k) % 4);
      if (r[c]) return c;
    end
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req = 4'b0;
    step();
    step();
    reset = 1'b0;
    ptr_m = 2'd3;
    res_hit_m = 1'b0;
    res_owner_m = 2'd0;
    hit_cnt_m = 4'd0;
  endtask

  // One full burst; from_idle selects whether an IDLE->ARB cycle precedes it, keep holds req through FLUSH.
  task automatic burst(input logic [3:0] reqv, input logic [7:0] bits, input bit from_idle,
                       input bit keep, input string tag);
    logic [1:0] o;
    logic [3:0] wv, exp_g;
    logic [6:0] pairs;
    o = rr_pick(ptr_m, reqv);
    exp_g = 4'b0001 << o;
    req = reqv;
    if (from_idle) begin
      step();
      total++;
      if ({gnt, det_w, det_reset, busy} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL %s arb_cycle got=%b exp=%b", tag, {gnt, det_w, det_reset, busy}, 7'b0000011);
      end
    end
    step();
    for (int k = 0; k < 8; k++) begin
      wv = 4'($urandom);
      wv[o] = bits[k];
      w = wv;
      #1;
      total++;
      if ({gnt, det_w, det_reset, busy, done} !== {exp_g, bits[k], 1'b0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL %s stream%0d got=%b exp=%b", tag, k, {gnt, det_w, det_reset, busy, done},
                 {exp_g, bits[k], 1'b0, 1'b1, 1'b0});
      end
      step();
    end
    total++;
    if ({gnt, det_w, det_reset, busy, done} !== {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL %s flush got=%b exp=%b", tag, {gnt, det_w, det_reset, busy, done}, 8'b00000010);
    end
    if (!keep) req = 4'b0;
    step();
    pairs = bits[7:1] & bits[6:0];
    res_hit_m = |pairs;
    hit_cnt_m = 4'($countones(pairs));
    res_owner_m = o;
    ptr_m = o;
    total++;
    if ({done, res_hit, res_owner} !== {1'b1, res_hit_m, res_owner_m}) begin
      bad++;
      $display("FAIL %s result got=%b exp=%b", tag, {done, res_hit, res_owner}, {1'b1, res_hit_m, res_owner_m});
    end
`ifdef ARB_HIT_COUNT_EN
    total++;
    if (hit_cnt !== hit_cnt_m) begin
      bad++;
      $display("FAIL %s hit_cnt got=%0d exp=%0d", tag, hit_cnt, hit_cnt_m);
    end
`endif
    total++;
    if ({busy, det_reset, det_w, gnt} !== {keep, 1'b1, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL %s after_flush got=%b exp=%b", tag, {busy, det_reset, det_w, gnt}, {keep, 7'b1000000});
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({gnt, det_w, det_reset, busy, done, res_hit, res_owner} !== 11'b0000_0_1_0_0_0_00) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {gnt, det_w, det_reset, busy, done, res_hit, res_owner},
               11'b00000100000);
    end
  endtask

  task automatic test_single();
    burst(4'b0001, 8'b0000_0011, 1'b1, 1'b0, "single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      burst(4'b1111, 8'($urandom), i == 0, i != 4, "rr");
      total++;
      if (res_owner !== 2'(i % 4)) begin
        bad++;
        $display("FAIL rr_order%0d got=%0d exp=%0d", i, res_owner, i % 4);
      end
    end
  endtask

  task automatic test_patterns();
    burst(4'b0100, 8'b0101_0101, 1'b1, 1'b0, "alternating");
    burst(4'b0100, 8'b1100_0000, 1'b1, 1'b0, "flush_hit");
    burst(4'b1000, 8'b1111_1111, 1'b1, 1'b0, "all_ones");
  endtask

  task automatic test_abort();
    logic [1:0] o;
    o = rr_pick(ptr_m, 4'b1111);
    req = 4'b1111;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      w = 4'($urandom);
      step();
    end
    req = 4'b1111 & ~(4'b0001 << o);
    step();
    ptr_m = o;
    total++;
    if ({busy, gnt, done, res_hit, res_owner} !== {1'b0, 4'b0000, 1'b0, res_hit_m, res_owner_m}) begin
      bad++;
      $display("FAIL abort got=%b exp=%b", {busy, gnt, done, res_hit, res_owner},
               {1'b0, 4'b0000, 1'b0, res_hit_m, res_owner_m});
    end
    req = 4'b0;
    step();
    total++;
    if ({busy, done, res_hit, res_owner} !== {1'b0, 1'b0, res_hit_m, res_owner_m}) begin
      bad++;
      $display("FAIL abort_settle got=%b exp=%b", {busy, done, res_hit, res_owner},
               {1'b0, 1'b0, res_hit_m, res_owner_m});
    end
    burst(4'b1111, 8'($urandom), 1'b1, 1'b0, "post_abort");
  endtask

  task automatic test_arb_drop();
    burst(4'b0010, 8'($urandom), 1'b1, 1'b1, "arb_drop_pre");
    req = 4'b0;
    step();
    total++;
    if ({busy, gnt, done} !== 6'b0_0000_0) begin
      bad++;
      $display("FAIL arb_drop got=%b exp=%b", {busy, gnt, done}, 6'b0);
    end
    burst(4'b1111, 8'($urandom), 1'b1, 1'b0, "arb_drop_post");
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    step();
    step();
    step();
    step();
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL mid_pre_gnt got=%b exp=%b", gnt, 4'b0100);
    end
    reset = 1'b1;
    req = 4'b0;
    step();
    reset = 1'b0;
    ptr_m = 2'd3;
    res_hit_m = 1'b0;
    res_owner_m = 2'd0;
    total++;
    if ({gnt, det_w, det_reset, busy, done, res_hit, res_owner} !== 11'b00000100000) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=%b", {gnt, det_w, det_reset, busy, done, res_hit, res_owner},
               11'b00000100000);
    end
    burst(4'b1111, 8'($urandom), 1'b1, 1'b0, "after_mid_reset");
    total++;
    if (res_owner !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset_owner got=%0d exp=0", res_owner);
    end
  endtask

  task automatic test_random();
    bit in_arb;
    bit keep;
    in_arb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      keep = (i == 19) ? 1'b0 : 1'($urandom_range(0, 1));
      burst(4'($urandom_range(1, 15)), 8'($urandom), !in_arb, keep, "random");
      in_arb = keep;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_patterns();
    test_abort();
    test_arb_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
